four_way_toom_cook_seq: RTL

FOUR_WAY_TOOM_COOK_SEQ -- requirements
Module: four_way_toom_cook_seq

---
 rtl/four_way_toom_cook_seq_pkg.sv | 30 +++
 rtl/four_way_toom_cook_seq_mac.sv | 43 ++++
 rtl/four_way_toom_cook_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/four_way_toom_cook_seq_pkg.sv
// Shared definitions for the four-way split GF(2) multiplier: FSM encoding,
// derived sizing constants and parameter legality check.
package four_way_toom_cook_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_COMBINE = 2'd2
  } state_t;

  // Quarter width QW = N/4.
  function automatic int unsigned qw_of(input int unsigned n);
    return n / 4;
  endfunction

  // Accumulate cycles per operation K = N/(4*DIGIT).
  function automatic int unsigned k_of(input int unsigned n, input int unsigned digit);
    return n / (4 * digit);
  endfunction

  // Digit counter must be able to hold K itself without wrapping.
  function automatic int unsigned cnt_w_of(input int unsigned n, input int unsigned digit);
    return $clog2(k_of(n, digit) + 1);
  endfunction

  function automatic bit params_ok(input int unsigned n, input int unsigned digit);
    return (n != 0) && (n % 4 == 0) && (digit != 0) && ((n / 4) % digit == 0);
  endfunction

endpackage

// File: rtl/four_way_toom_cook_seq_mac.sv
// One partial-product lane: digit-serial carry-less multiply of a quarter of a
// by a quarter of b, folded into an N/2-bit accumulator.
module gf2_digit_mac #(
  parameter int QW    = 4,
  parameter int DIGIT = 2,
  parameter int CW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [QW-1:0]     b_j,
  input  logic [DIGIT-1:0]  a_digit,
  input  logic [CW-1:0]     t,
  output logic [2*QW-1:0]   acc
);

  logic [2*QW-1:0] partial;
  logic [2*QW-1:0] acc_reg;

  // b_j times the current digit, before positioning by digit index t.
  always_comb begin
    partial = '0;
    for (int m = 0; m < DIGIT; m++) begin
      if (a_digit[m]) begin
        partial = partial ^ ({{QW{1'b0}}, b_j} << m);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_reg ^ (partial << (int'(t) * DIGIT));
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/four_way_toom_cook_seq.sv
// Sequential carry-less (GF(2)) multiplier: 16 digit-serial quarter-product
// lanes run in parallel, then the partial products are recombined into c.
module four_way_toom_cook_seq
  import four_way_toom_cook_seq_pkg::*;
#(
  parameter int N     = 1024,
  parameter int DIGIT = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] c
);

  localparam int QW = qw_of(N);
  localparam int K  = k_of(N, DIGIT);
  localparam int CW = cnt_w_of(N, DIGIT);
  localparam logic [CW-1:0] K_CNT = CW'(K);

  generate
    if (!params_ok(N, DIGIT)) begin : g_bad_params
      $fatal(1, "four_way_toom_cook_seq: N must be a multiple of 4 and DIGIT must divide N/4");
    end
  endgenerate

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [N-1:0]    a_reg;
  logic [N-1:0]    b_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [2*N-1:0]  c_reg;
  logic [2*N-1:0]  c_next;

  logic            lane_clr;
  logic            lane_en;
  logic [2*QW-1:0] p [16];
  logic [2*QW-1:0] q [7];

  assign lane_clr = (state_reg == ST_IDLE) && start;
  assign lane_en  = (state_reg == ST_RUN) && (cnt_reg != K_CNT);

  // Lane gi multiplies quarter a_i (i = gi/4) by quarter b_j (j = gi%4).
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_lane
      localparam int QI = gi / 4;
      localparam int QJ = gi % 4;
      logic [DIGIT-1:0] a_digit;

      assign a_digit = a_reg[QI*QW + int'(cnt_reg)*DIGIT +: DIGIT];

      gf2_digit_mac #(
        .QW    (QW),
        .DIGIT (DIGIT),
        .CW    (CW)
      ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clr     (lane_clr),
        .en      (lane_en),
        .b_j     (b_reg[QJ*QW +: QW]),
        .a_digit (a_digit),
        .t       (cnt_reg),
        .acc     (p[gi])
      );
    end
  endgenerate

  // Coefficients q_k collect p_ij with i+j=k; each lands at offset k*QW.
  always_comb begin
    for (int k = 0; k < 7; k++) begin
      q[k] = '0;
    end
    for (int l = 0; l < 16; l++) begin
      q[(l / 4) + (l % 4)] = q[(l / 4) + (l % 4)] ^ p[l];
    end
    c_next = '0;
    for (int k = 0; k < 7; k++) begin
      c_next = c_next ^ ({{(2*N-2*QW){1'b0}}, q[k]} << (k * QW));
    end
  end

  // RUN stays one extra cycle with cnt_reg == K so the counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      c_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (cnt_reg == K_CNT) begin
            state_reg <= ST_COMBINE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_COMBINE: begin
          c_reg     <= c_next;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign c    = c_reg;

endmodule
